// File: rtl/psram_frame_arbiter_if.sv
// Requester and PSRAM-controller side signals of psram_frame_arbiter.
// slave: the arbiter; master: the surrounding requesters and controller.
interface psram_frame_arbiter_if #(
  parameter int ADDR_WIDTH = 21,
  parameter int DATA_WIDTH = 32
);
  logic                  init_done;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data_in;
  logic                  wr_data_rd;
  logic                  wr_gnt;
  logic                  wr_done;
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_urgent;
  logic                  rd_gnt;
  logic [DATA_WIDTH-1:0] rd_data_out;
  logic                  rd_valid_out;
  logic                  rd_done;
  logic                  cmd;
  logic                  cmd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            data_mask;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_data_valid;
  logic                  error;
  logic                  busy;

  modport slave (
    input  init_done, wr_req, wr_addr, wr_data_in,
    input  rd_req, rd_addr, rd_urgent,
    input  rd_data, rd_data_valid,
    output wr_data_rd, wr_gnt, wr_done,
    output rd_gnt, rd_data_out, rd_valid_out, rd_done,
    output cmd, cmd_en, addr, wr_data, data_mask,
    output error, busy
  );

  modport master (
    output init_done, wr_req, wr_addr, wr_data_in,
    output rd_req, rd_addr, rd_urgent,
    output rd_data, rd_data_valid,
    input  wr_data_rd, wr_gnt, wr_done,
    input  rd_gnt, rd_data_out, rd_valid_out, rd_done,
    input  cmd, cmd_en, addr, wr_data, data_mask,
    input  error, busy
  );
endinterface

// File: rtl/psram_frame_arbiter.sv
// Burst arbiter sharing one PSRAM channel between camera writes and LCD reads.
// Define ARB_TIMEOUT_EN to add a read-data watchdog in RD_WAIT.
module psram_frame_arbiter #(
  parameter int ADDR_WIDTH  = 21,
  parameter int DATA_WIDTH  = 32,
  parameter int BURST_WORDS = 16,
  parameter int CMD_GAP     = 4,
  parameter int RD_TIMEOUT  = 255
) (
  input logic clk,
  input logic rst,
  psram_frame_arbiter_if.slave bus
);

  localparam int BW = $clog2(BURST_WORDS + 1);
  localparam int GW = $clog2(CMD_GAP + 1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] WR_BURST = 2'd1;
  localparam logic [1:0] RD_WAIT  = 2'd2;
  localparam logic [1:0] GAP      = 2'd3;

  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST_WORDS - 1);
  localparam logic [GW-1:0] LAST_GAP  = GW'(CMD_GAP - 1);

  if (BURST_WORDS < 2 || BURST_WORDS > 255 || CMD_GAP < 1 ||
      RD_TIMEOUT < 1) begin : g_bad_cfg
    $error("psram_frame_arbiter: illegal parameter set");
  end

  logic [1:0]            state_q, state_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [GW-1:0]         gap_q, gap_d;
  logic                  last_wr_q, last_wr_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  cmd_q, cmd_d;
  logic                  cmd_en_q, cmd_en_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  rd_done_q, rd_done_d;
  logic                  error_q, error_d;

`ifdef ARB_TIMEOUT_EN
  localparam int WW = $clog2(RD_TIMEOUT + 1);
  logic [WW-1:0] wd_q, wd_d;
`endif

  logic grant_ok;
  logic rd_sel;
  logic wr_sel;
  logic wr_pop;
  logic beat_in;
  logic wr_last;

  // Grant strobes are combinational, so they are gated by rst as well.
  assign grant_ok = !rst && state_q == IDLE && bus.init_done;
  assign rd_sel   = grant_ok && bus.rd_req &&
                    (bus.rd_urgent || !bus.wr_req || last_wr_q);
  assign wr_sel   = grant_ok && bus.wr_req && !rd_sel;
  assign wr_pop   = wr_sel ||
                    (state_q == WR_BURST && beat_q < LAST_BEAT);
  assign beat_in  = state_q == RD_WAIT && bus.rd_data_valid;
  assign wr_last  = state_q == WR_BURST && beat_q == LAST_BEAT;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    gap_d      = gap_q;
    last_wr_d  = last_wr_q;
    addr_d     = addr_q;
    cmd_d      = 1'b0;
    cmd_en_d   = 1'b0;
    wr_data_d  = wr_data_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_done_d  = 1'b0;
    error_d    = error_q;
`ifdef ARB_TIMEOUT_EN
    wd_d       = wd_q;
`endif

    if (wr_pop) wr_data_d = bus.wr_data_in;

    if (beat_in) begin
      rd_data_d  = bus.rd_data;
      rd_valid_d = 1'b1;
    end

    // Beats outside a read window are dropped and flagged.
    if (bus.rd_data_valid && !beat_in) error_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        beat_d = '0;
        gap_d  = '0;
`ifdef ARB_TIMEOUT_EN
        wd_d   = '0;
`endif
        if (rd_sel) begin
          state_d   = RD_WAIT;
          addr_d    = bus.rd_addr;
          cmd_en_d  = 1'b1;
          last_wr_d = 1'b0;
        end else if (wr_sel) begin
          state_d   = WR_BURST;
          addr_d    = bus.wr_addr;
          cmd_en_d  = 1'b1;
          cmd_d     = 1'b1;
          last_wr_d = 1'b1;
        end
      end
      WR_BURST: begin
        if (wr_last) state_d = GAP;
        else beat_d = beat_q + 1'b1;
      end
      RD_WAIT: begin
        if (beat_in) begin
          if (beat_q == LAST_BEAT) begin
            rd_done_d = 1'b1;
            state_d   = GAP;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        wd_d = (cmd_en_q || beat_in) ? WW'(1) : wd_q + 1'b1;
        if (!beat_in && wd_d == WW'(RD_TIMEOUT)) begin
          error_d   = 1'b1;
          rd_done_d = 1'b1;
          state_d   = GAP;
        end
`endif
      end
      GAP: begin
        if (gap_q == LAST_GAP) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      gap_q      <= '0;
      last_wr_q  <= 1'b0;
      addr_q     <= '0;
      cmd_q      <= 1'b0;
      cmd_en_q   <= 1'b0;
      wr_data_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_done_q  <= 1'b0;
      error_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      wd_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      gap_q      <= gap_d;
      last_wr_q  <= last_wr_d;
      addr_q     <= addr_d;
      cmd_q      <= cmd_d;
      cmd_en_q   <= cmd_en_d;
      wr_data_q  <= wr_data_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_done_q  <= rd_done_d;
      error_q    <= error_d;
`ifdef ARB_TIMEOUT_EN
      wd_q       <= wd_d;
`endif
    end
  end

  assign bus.wr_gnt       = wr_sel;
  assign bus.rd_gnt       = rd_sel;
  assign bus.wr_data_rd   = wr_pop;
  assign bus.wr_done      = wr_last;
  assign bus.rd_data_out  = rd_data_q;
  assign bus.rd_valid_out = rd_valid_q;
  assign bus.rd_done      = rd_done_q;
  assign bus.cmd          = cmd_q;
  assign bus.cmd_en       = cmd_en_q;
  assign bus.addr         = addr_q;
  assign bus.wr_data      = wr_data_q;
  assign bus.data_mask    = 4'h0;
  assign bus.error        = error_q;
  assign bus.busy         = state_q != IDLE;

endmodule

// File: tb/tb_psram_frame_arbiter.sv
// Directed bench for psram_frame_arbiter: bursts, arbitration, errors, reset.
// Honours ARB_TIMEOUT_EN for the read watchdog step.
module tb_psram_frame_arbiter;

  localparam int AW = 21;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] wr_ptr;

  int checks = 0;
  int failures = 0;

  psram_frame_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  psram_frame_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WORDS(16),
    .CMD_GAP(4), .RD_TIMEOUT(255)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // First-word-fall-through source: word value equals pop count.
  always @(posedge clk or posedge rst) begin
    if (rst) wr_ptr <= '0;
    else if (bus.wr_data_rd) wr_ptr <= wr_ptr + 1;
  end
  assign bus.wr_data_in = wr_ptr;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (bus.busy == 1'b0) break;
      tick();
    end
    check("wait_idle", 64'(bus.busy), 64'(0));
  endtask

  task automatic wait_gnt(output logic w, output logic r);
    int n;
    n = 0;
    while (!(bus.wr_gnt || bus.rd_gnt) && n < 60) begin
      tick();
      #1;
      n++;
    end
    check("gnt_seen", 64'(bus.wr_gnt || bus.rd_gnt), 64'(1));
    w = bus.wr_gnt;
    r = bus.rd_gnt;
  endtask

  task automatic read_beats(input logic [DW-1:0] base);
    for (int b = 0; b < 16; b++) begin
      bus.rd_data_valid = 1'b1;
      bus.rd_data = base + DW'(b);
      tick();
    end
    bus.rd_data_valid = 1'b0;
  endtask

  initial begin
    logic w, r, exp_rd;
    int n;
    bus.init_done = 1'b0;
    bus.wr_req = 1'b0;
    bus.wr_addr = '0;
    bus.rd_req = 1'b0;
    bus.rd_addr = '0;
    bus.rd_urgent = 1'b0;
    bus.rd_data = '0;
    bus.rd_data_valid = 1'b0;

    #3;
    check("rst_cmd_en", 64'(bus.cmd_en), 64'(0));
    check("rst_addr", 64'(bus.addr), 64'(0));
    check("rst_wr_data", 64'(bus.wr_data), 64'(0));
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_error", 64'(bus.error), 64'(0));
    check("rst_rd_valid", 64'(bus.rd_valid_out), 64'(0));
    check("rst_mask", 64'(bus.data_mask), 64'(0));
    tick();
    tick();
    rst = 1'b0;
    tick();

    // No grant before calibration completes
    bus.wr_req = 1'b1;
    bus.wr_addr = 21'h1000;
    #1;
    check("no_init_gnt", 64'(bus.wr_gnt), 64'(0));
    tick();
    check("no_init_busy", 64'(bus.busy), 64'(0));

    // Single write burst
    bus.init_done = 1'b1;
    #1;
    check("wr_gnt", 64'(bus.wr_gnt), 64'(1));
    check("wr_pop0", 64'(bus.wr_data_rd), 64'(1));
    tick();
    bus.wr_req = 1'b0;
    check("wr_cmd_en", 64'(bus.cmd_en), 64'(1));
    check("wr_cmd", 64'(bus.cmd), 64'(1));
    check("wr_addr", 64'(bus.addr), 64'(21'h1000));
    check("wr_word0", 64'(bus.wr_data), 64'(0));
    check("wr_busy", 64'(bus.busy), 64'(1));
    for (int k = 1; k < 16; k++) begin
      tick();
      check("wr_word", 64'(bus.wr_data), 64'(k));
      check("wr_done", 64'(bus.wr_done), 64'(k == 15));
      check("wr_cmd_en_low", 64'(bus.cmd_en), 64'(0));
    end
    check("wr_pop_end", 64'(bus.wr_data_rd), 64'(0));
    bus.wr_req = 1'b1;
    bus.wr_addr = 21'h1100;
    n = 0;
    #1;
    while (!bus.wr_gnt && n < 20) begin
      tick();
      #1;
      n++;
    end
    check("wr_spacing", 64'(n), 64'(5));
    tick();
    bus.wr_req = 1'b0;
    check("wr2_addr", 64'(bus.addr), 64'(21'h1100));
    check("wr2_word0", 64'(bus.wr_data), 64'(16));
    wait_idle(40);

    // Single read burst, data after 10 cycles
    bus.rd_req = 1'b1;
    bus.rd_addr = 21'h2000;
    #1;
    check("rd_gnt", 64'(bus.rd_gnt), 64'(1));
    check("rd_no_wr_gnt", 64'(bus.wr_gnt), 64'(0));
    tick();
    bus.rd_req = 1'b0;
    check("rd_cmd_en", 64'(bus.cmd_en), 64'(1));
    check("rd_cmd", 64'(bus.cmd), 64'(0));
    check("rd_addr", 64'(bus.addr), 64'(21'h2000));
    repeat (10) tick();
    check("rd_wait_busy", 64'(bus.busy), 64'(1));
    for (int b = 0; b < 16; b++) begin
      bus.rd_data_valid = 1'b1;
      bus.rd_data = 32'hA0 + DW'(b);
      tick();
      check("rd_valid", 64'(bus.rd_valid_out), 64'(1));
      check("rd_data", 64'(bus.rd_data_out), 64'(32'hA0 + b));
      check("rd_done", 64'(bus.rd_done), 64'(b == 15));
    end
    bus.rd_data_valid = 1'b0;
    tick();
    check("rd_valid_end", 64'(bus.rd_valid_out), 64'(0));
    check("rd_done_end", 64'(bus.rd_done), 64'(0));
    check("rd_error", 64'(bus.error), 64'(0));
    wait_idle(20);

    // Contention: W,R,W,R then urgent R,R,R
    bus.wr_req = 1'b1;
    bus.rd_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.rd_urgent = (i >= 4);
      exp_rd = (i >= 4) ? 1'b1 : (i % 2 == 1);
      #1;
      wait_gnt(w, r);
      check("arb_rd", 64'(r), 64'(exp_rd));
      check("arb_wr", 64'(w), 64'(!exp_rd));
      tick();
      if (r) read_beats(32'h100 * i);
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    bus.rd_urgent = 1'b0;
    wait_idle(40);
    check("arb_error", 64'(bus.error), 64'(0));

    // Read with no returned data
    bus.rd_req = 1'b1;
    bus.rd_addr = 21'h3000;
    #1;
    tick();
    bus.rd_req = 1'b0;
    check("wd_cmd_en", 64'(bus.cmd_en), 64'(1));
`ifdef ARB_TIMEOUT_EN
    n = 0;
    while (!bus.rd_done && n < 300) begin
      tick();
      n++;
    end
    check("wd_latency", 64'(n), 64'(255));
    check("wd_error", 64'(bus.error), 64'(1));
    wait_idle(20);
`else
    repeat (300) tick();
    check("nowd_busy", 64'(bus.busy), 64'(1));
    check("nowd_done", 64'(bus.rd_done), 64'(0));
    check("nowd_error", 64'(bus.error), 64'(0));
    read_beats(32'h500);
    wait_idle(20);
`endif

    // Stray beat while idle
    bus.rd_data_valid = 1'b1;
    bus.rd_data = 32'hDEAD;
    tick();
    bus.rd_data_valid = 1'b0;
    check("stray_error", 64'(bus.error), 64'(1));
    check("stray_drop", 64'(bus.rd_valid_out), 64'(0));
    repeat (5) tick();
    check("stray_sticky", 64'(bus.error), 64'(1));

    // Reset in the middle of a write burst
    bus.wr_req = 1'b1;
    bus.wr_addr = 21'h4000;
    #1;
    check("rw_gnt", 64'(bus.wr_gnt), 64'(1));
    tick();
    bus.wr_req = 1'b0;
    repeat (7) tick();
    check("rw_beat7_busy", 64'(bus.busy), 64'(1));
    rst = 1'b1;
    bus.wr_req = 1'b1;
    #1;
    check("rw_cmd_en", 64'(bus.cmd_en), 64'(0));
    check("rw_wr_data", 64'(bus.wr_data), 64'(0));
    check("rw_addr", 64'(bus.addr), 64'(0));
    check("rw_busy", 64'(bus.busy), 64'(0));
    check("rw_pop", 64'(bus.wr_data_rd), 64'(0));
    check("rw_gnt_rst", 64'(bus.wr_gnt), 64'(0));
    check("rw_error", 64'(bus.error), 64'(0));
    tick();
    rst = 1'b0;
    #1;
    check("rw_regnt", 64'(bus.wr_gnt), 64'(1));
    tick();
    bus.wr_req = 1'b0;
    check("rw2_cmd_en", 64'(bus.cmd_en), 64'(1));
    check("rw2_cmd", 64'(bus.cmd), 64'(1));
    check("rw2_addr", 64'(bus.addr), 64'(21'h4000));
    check("rw2_word0", 64'(bus.wr_data), 64'(0));
    wait_idle(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/psram_frame_arbiter.md
# psram_frame_arbiter

Burst-level arbiter sharing one PSRAM controller channel (cmd/cmd_en/addr/wr_data/rd_data) between a write requester (camera pixel path storing lines into the frame buffer) and a read requester (LCD prefetch path fetching lines for display). It sits between the video controller's requester logic and the frame-buffer channel 0. It issues one fixed-length burst per grant, enforces the controller's minimum command spacing, and reports protocol errors.

## Interface
- ADDR_WIDTH, 21, PSRAM word address width
- DATA_WIDTH, 32, data word width
- BURST_WORDS, 16, words per burst (2..255)
- CMD_GAP, 4, idle cycles after a burst completes before the next cmd_en (>=1)
- RD_TIMEOUT, 255, read watchdog limit in cycles (used only with ARB_TIMEOUT_EN)

Ports:
- clk  in  1  memory-side clock (controller clk_out)
- rst  in  1  reset; asynchronous, active-high
- init_done  in  1  PSRAM calibration complete; no grants while low
- wr_req  in  1  write burst request; held until wr_gnt
- wr_addr  in  ADDR_WIDTH  burst start address, sampled at grant
- wr_data_in  in  DATA_WIDTH  first-word-fall-through write data
- wr_data_rd  out  1  pop strobe for wr_data_in
- wr_gnt  out  1  one-cycle grant pulse
- wr_done  out  1  one-cycle pulse, burst fully issued
- rd_req  in  1  read burst request; held until rd_gnt
- rd_addr  in  ADDR_WIDTH  burst start address, sampled at grant
- rd_urgent  in  1  read consumer near empty; forces read priority
- rd_gnt  out  1  one-cycle grant pulse
- rd_data_out  out  DATA_WIDTH  registered read data
- rd_valid_out  out  1  rd_data_out qualifier
- rd_done  out  1  one-cycle pulse after last beat (or timeout)
- cmd  out  1  1=write, 0=read
- cmd_en  out  1  command strobe
- addr  out  ADDR_WIDTH  command address
- wr_data  out  DATA_WIDTH  write data to controller
- data_mask  out  4  tied 4'h0
- rd_data  in  DATA_WIDTH  controller read data
- rd_data_valid  in  1  controller read beat valid
- error  out  1  sticky protocol error
- busy  out  1  state != IDLE

## Operation
- States: IDLE, WR_BURST, RD_WAIT, GAP.
- IDLE, init_done=1: grant read if rd_req && (rd_urgent || !wr_req || last_grant==WR); else grant write if wr_req. last_grant resets to RD (first contention goes to write).
- Grant cycle: gnt pulses combinationally; on the edge the address is latched into addr, cmd_en/cmd registered high for exactly one cycle.
- Write: wr_data_rd high in the grant cycle and the following BURST_WORDS-1 cycles; wr_data captures wr_data_in on each of those edges, so word k is on wr_data k cycles after cmd_en (word 0 aligned with cmd_en). WR_BURST counts BURST_WORDS cycles, pulses wr_done on the last, enters GAP.
- Read: enter RD_WAIT; each rd_data_valid beat is registered to rd_data_out/rd_valid_out (1-cycle latency). On beat BURST_WORDS, pulse rd_done together with the last rd_valid_out and enter GAP.
- GAP: count CMD_GAP cycles, return to IDLE; requests are ignored during GAP.
- rd_data_valid outside RD_WAIT, or beats beyond BURST_WORDS: set error, beat dropped.
- Beat counter width ceil(log2(BURST_WORDS+1)); no wrap within a burst.

## Timing
- Reset values: all outputs 0, addr 0, state IDLE, error 0.
- Grant-to-cmd_en latency 1 cycle; back-to-back grant spacing = 1 + BURST_WORDS + CMD_GAP cycles for writes, read spacing = data return + CMD_GAP + 1.
- Simultaneous wr_req/rd_req alternate unless rd_urgent.
- rst mid-burst: immediate abort, all state cleared; requesters must re-request; partial data is discarded.
- init_done falling: current burst completes; no new grants.

## Configuration
- ARB_TIMEOUT_EN defined: RD_WAIT counter reloads on cmd_en and on each beat; if it reaches RD_TIMEOUT, set error, pulse rd_done, enter GAP.
- Undefined: RD_WAIT waits indefinitely; no watchdog logic.

## Test plan
- Single write, BURST_WORDS=16, addr 0x1000, data 0..15 -> cmd_en one cycle with cmd=1 addr=0x1000, wr_data 0..15 on consecutive cycles, wr_done on word 15, next cmd_en no earlier than 4 cycles later.
- Single read addr 0x2000, controller returns 16 beats after 10 cycles -> 16 rd_valid_out each 1 cycle after rd_data_valid, rd_done with beat 16, error=0.
- wr_req and rd_req held continuously, rd_urgent=0 -> grants W,R,W,R; with rd_urgent=1 -> R,R,R.
- Stray rd_data_valid in IDLE -> error=1 and stays 1 until rst.
- ARB_TIMEOUT_EN, RD_TIMEOUT=255, no read data -> error=1 and rd_done 255 cycles after cmd_en; without macro, busy stays 1.
- rst asserted at write beat 7 -> all outputs 0 the same cycle; after release, a new wr_req is granted normally.
